// File: rtl/reg_stream_pkg.sv
// Shared types and default sizing for the register-stream arbiter.
// Holds the arbiter FSM encoding and default NUM_REQ/DATA_W/QUANTUM.
package reg_stream_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_QUANTUM = 4;

endpackage

// File: rtl/arb_out_slice.sv
// Two-entry {id, data} output buffer with ping-pong pointers.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_id/in_data
// upstream; out_valid/out_ready/out_id/out_data downstream.
module arb_out_slice #(
   parameter int ID_W   = 2,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ID_W-1:0]   in_id,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ID_W-1:0]   out_id,
   output logic [DATA_W-1:0] out_data
);

   localparam int ENT_W = ID_W + DATA_W;

   logic [ENT_W-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign {out_id, out_data} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         // entries cleared so the outputs read zero out of reset
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {in_id, in_data};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/reg_stream_arb.sv
// Quantum-limited round-robin arbiter merging NUM_REQ streams into one.
// Ports: CLK_I, RST_I (sync, active-high); S_WVALID/S_WREADY/S_WDATA per
// requester; M_WVALID/M_WREADY/M_WDATA/M_WID merged output.
// Macro REG_STREAM_ARB_FIXED_PRIO_EN: pin search pointer to 0 (fixed prio).
module reg_stream_arb
   import reg_stream_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int QUANTUM = DEF_QUANTUM
) (
   input  logic                        CLK_I,
   input  logic                        RST_I,
   input  logic [NUM_REQ-1:0]          S_WVALID,
   output logic [NUM_REQ-1:0]          S_WREADY,
   input  logic [NUM_REQ*DATA_W-1:0]   S_WDATA,
   output logic                        M_WVALID,
   input  logic                        M_WREADY,
   output logic [DATA_W-1:0]           M_WDATA,
   output logic [$clog2(NUM_REQ)-1:0]  M_WID
);

   localparam int ID_W = $clog2(NUM_REQ);

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   g_q, g_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [7:0]        cnt_q, cnt_d;

   logic              search_hit;
   logic [ID_W-1:0]   search_idx;
   logic [ID_W:0]     sum;
   logic              grant_valid;
   logic [DATA_W-1:0] grant_data;
   logic              slice_ready;
   logic              accept;
   logic              last_beat;
   logic [ID_W-1:0]   ptr_next;

   // Rotating search: walk offsets high to low so the lowest offset
   // from ptr_q that is valid wins.
   always_comb begin
      search_hit = 1'b0;
      search_idx = '0;
      sum        = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, ptr_q} + (ID_W+1)'(i);
         if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
         end
         if (S_WVALID[sum[ID_W-1:0]]) begin
            search_hit = 1'b1;
            search_idx = sum[ID_W-1:0];
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (g_q == ID_W'(i)) begin
            grant_data = S_WDATA[i*DATA_W +: DATA_W];
         end
      end
   end

   assign grant_valid = S_WVALID[g_q];
   assign accept      = (state_q == GRANT) & grant_valid & slice_ready;
   assign last_beat   = (cnt_q == 8'(QUANTUM - 1));

`ifdef REG_STREAM_ARB_FIXED_PRIO_EN
   assign ptr_next = '0;
`else
   assign ptr_next = (g_q == ID_W'(NUM_REQ - 1)) ? '0 : g_q + ID_W'(1);
`endif

   always_comb begin
      S_WREADY = '0;
      if (state_q == GRANT) begin
         S_WREADY[g_q] = slice_ready;
      end
   end

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (search_hit) begin
               state_d = GRANT;
               g_d     = search_idx;
            end
         end
         GRANT: begin
            if (accept) begin
               cnt_d = cnt_q + 8'd1;
            end
            // a stalled-but-valid requester keeps the grant; a dropped
            // valid gives it up immediately
            if (!grant_valid || (accept && last_beat)) begin
               state_d = IDLE;
               cnt_d   = '0;
               ptr_d   = ptr_next;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   arb_out_slice #(
      .ID_W   (ID_W),
      .DATA_W (DATA_W)
   ) u_slice (
      .clk       (CLK_I),
      .rst       (RST_I),
      .in_valid  (accept),
      .in_ready  (slice_ready),
      .in_id     (g_q),
      .in_data   (grant_data),
      .out_valid (M_WVALID),
      .out_ready (M_WREADY),
      .out_id    (M_WID),
      .out_data  (M_WDATA)
   );

endmodule

// File: tb/tb_reg_stream_arb.sv
// Directed bench for reg_stream_arb (NUM_REQ=4, DATA_W=8, QUANTUM=4).
// Vector table for a single-requester stream plus corner-case sequences.
module tb_reg_stream_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  s_wvalid;
   logic [3:0]  s_wready;
   logic [31:0] s_wdata;
   logic        m_wvalid;
   logic        m_wready;
   logic [7:0]  m_wdata;
   logic [1:0]  m_wid;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   reg_stream_arb #(
      .NUM_REQ (4),
      .DATA_W  (8),
      .QUANTUM (4)
   ) dut (
      .CLK_I    (clk),
      .RST_I    (rst),
      .S_WVALID (s_wvalid),
      .S_WREADY (s_wready),
      .S_WDATA  (s_wdata),
      .M_WVALID (m_wvalid),
      .M_WREADY (m_wready),
      .M_WDATA  (m_wdata),
      .M_WID    (m_wid)
   );

   typedef struct {
      logic [3:0] valid;
      logic       mrdy;
      logic [7:0] d2;
      logic [3:0] e_rdy;
      logic       e_mv;
      logic [7:0] e_md;
   } vec_t;

   vec_t vt [12];

   function automatic vec_t mk(logic [3:0] v, logic mr, logic [7:0] d,
                               logic [3:0] er, logic emv, logic [7:0] emd);
      vec_t r;
      r.valid = v;
      r.mrdy  = mr;
      r.d2    = d;
      r.e_rdy = er;
      r.e_mv  = emv;
      r.e_md  = emd;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      s_wvalid = '0;
      s_wdata  = '0;
      m_wready = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_wready", 32'(s_wready), 0);
      chk("rst_mvalid", 32'(m_wvalid), 0);
      rst = 1'b0;
   endtask

   int cnt [4];
   int ocnt [4];
   int got;
   int eid;
   logic [7:0] held;

   initial begin
      rst      = 1'b1;
      s_wvalid = '0;
      s_wdata  = '0;
      m_wready = 1'b0;

      // reset values and idle after release
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_wready", 32'(s_wready), 0);
      chk("rst_mvalid", 32'(m_wvalid), 0);
      chk("rst_mdata", 32'(m_wdata), 0);
      chk("rst_mid", 32'(m_wid), 0);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         chk("idle_wready", 32'(s_wready), 0);
         chk("idle_mvalid", 32'(m_wvalid), 0);
      end

      // requester 2 streams 1..8: blocks of 4 with one bubble between
      vt[0]  = mk(4'b0100, 1, 8'd1, 4'b0000, 0, 8'd0);
      vt[1]  = mk(4'b0100, 1, 8'd1, 4'b0100, 0, 8'd0);
      vt[2]  = mk(4'b0100, 1, 8'd2, 4'b0100, 1, 8'd1);
      vt[3]  = mk(4'b0100, 1, 8'd3, 4'b0100, 1, 8'd2);
      vt[4]  = mk(4'b0100, 1, 8'd4, 4'b0100, 1, 8'd3);
      vt[5]  = mk(4'b0100, 1, 8'd5, 4'b0000, 1, 8'd4);
      vt[6]  = mk(4'b0100, 1, 8'd5, 4'b0100, 0, 8'd0);
      vt[7]  = mk(4'b0100, 1, 8'd6, 4'b0100, 1, 8'd5);
      vt[8]  = mk(4'b0100, 1, 8'd7, 4'b0100, 1, 8'd6);
      vt[9]  = mk(4'b0100, 1, 8'd8, 4'b0100, 1, 8'd7);
      vt[10] = mk(4'b0000, 1, 8'd0, 4'b0000, 1, 8'd8);
      vt[11] = mk(4'b0000, 1, 8'd0, 4'b0000, 0, 8'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         s_wvalid = vt[i].valid;
         m_wready = vt[i].mrdy;
         s_wdata  = {8'd0, vt[i].d2, 16'd0};
         #1;
         chk($sformatf("vec%0d_wready", i), 32'(s_wready), 32'(vt[i].e_rdy));
         chk($sformatf("vec%0d_mvalid", i), 32'(m_wvalid), 32'(vt[i].e_mv));
         if (vt[i].e_mv) begin
            chk($sformatf("vec%0d_mdata", i), 32'(m_wdata), 32'(vt[i].e_md));
            chk($sformatf("vec%0d_mid", i), 32'(m_wid), 2);
         end
      end

      // all four valid: grants rotate 0,1,2,3,0 in blocks of 4
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cnt[i]  = 0;
         ocnt[i] = 0;
      end
      got = 0;
      for (int c = 0; c < 200 && got < 20; c++) begin
         @(negedge clk);
         s_wvalid = 4'hF;
         m_wready = 1'b1;
         for (int i = 0; i < 4; i++) s_wdata[i*8 +: 8] = 8'(i*16 + cnt[i]);
         #1;
         chk("onehot_wready", 32'($countones(s_wready) <= 1), 1);
         if (m_wvalid && m_wready) begin
`ifdef REG_STREAM_ARB_FIXED_PRIO_EN
            eid = 0;
`else
            eid = (got / 4) % 4;
`endif
            chk($sformatf("rr_id%0d", got), 32'(m_wid), 32'(eid));
            chk($sformatf("rr_data%0d", got), 32'(m_wdata),
                32'(eid*16 + ocnt[eid]));
            ocnt[eid]++;
            got++;
         end
         for (int i = 0; i < 4; i++) if (s_wvalid[i] && s_wready[i]) cnt[i]++;
      end
      chk("rr_done", 32'(got), 20);

      // backpressure: exactly two beats buffered, output held, then drain
      do_reset();
      cnt[0] = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         s_wvalid = 4'b0001;
         m_wready = 1'b0;
         s_wdata  = {24'd0, 8'(cnt[0])};
         #1;
         if (c == 3) held = m_wdata;
         if (c >= 3) begin
            chk("bp_wready", 32'(s_wready), 0);
            chk("bp_mvalid", 32'(m_wvalid), 1);
            chk("bp_mdata", 32'(m_wdata), 0);
            chk("bp_hold", 32'(m_wdata), 32'(held));
         end
         if (s_wvalid[0] && s_wready[0]) cnt[0]++;
      end
      chk("bp_buffered", 32'(cnt[0]), 2);
      got = 0;
      for (int c = 0; c < 60 && got < 10; c++) begin
         @(negedge clk);
         s_wvalid = 4'b0001;
         m_wready = 1'b1;
         s_wdata  = {24'd0, 8'(cnt[0])};
         #1;
         if (m_wvalid && m_wready) begin
            chk($sformatf("bp_drain%0d", got), 32'(m_wdata), 32'(got));
            got++;
         end
         if (s_wvalid[0] && s_wready[0]) cnt[0]++;
      end
      chk("bp_done", 32'(got), 10);

      // requester 1 drops after 2 beats; grant moves to 3 past a re-raised 1
      do_reset();
      m_wready = 1'b1;
      @(negedge clk);
      s_wvalid = 4'b1010;
      #1 chk("drop_c0", 32'(s_wready), 32'b0000);
      @(negedge clk);
      #1 chk("drop_c1", 32'(s_wready), 32'b0010);
      @(negedge clk);
      #1 chk("drop_c2", 32'(s_wready), 32'b0010);
      @(negedge clk);
      s_wvalid = 4'b1000;
      #1 chk("drop_c3", 32'(s_wready), 32'b0010);
      @(negedge clk);
      s_wvalid = 4'b1010;
      #1 chk("drop_c4", 32'(s_wready), 32'b0000);
      @(negedge clk);
`ifdef REG_STREAM_ARB_FIXED_PRIO_EN
      #1 chk("drop_c5", 32'(s_wready), 32'b0010);
`else
      #1 chk("drop_c5", 32'(s_wready), 32'b1000);
`endif

      // reset pulse with two beats buffered
      do_reset();
      m_wready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         s_wvalid = 4'b0100;
         #1;
      end
      chk("rp_full_mvalid", 32'(m_wvalid), 1);
      chk("rp_full_wready", 32'(s_wready), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      s_wvalid = 4'b0110;
      #1;
      chk("rp_mvalid", 32'(m_wvalid), 0);
      chk("rp_idle", 32'(s_wready), 0);
      @(negedge clk);
      #1;
      chk("rp_grant", 32'(s_wready), 32'b0010);
      chk("rp_empty", 32'(m_wvalid), 0);
      @(negedge clk);
      m_wready = 1'b1;
      s_wvalid = 4'b0000;
      #1;
      chk("rp_out_valid", 32'(m_wvalid), 1);
      chk("rp_out_id", 32'(m_wid), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_stream_arb.md
REG_STREAM_ARB -- requirements
Module: reg_stream_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting streams, 2..8.
REQ-002 Parameter DATA_W, default 8, data width per stream.
REQ-003 Parameter QUANTUM, default 4, maximum beats per grant, 1..255.
REQ-004 CLK_I  input  1  sole clock; all logic on its rising edge.
REQ-005 RST_I  input  1  synchronous, active-high reset.
REQ-006 S_WVALID  input  NUM_REQ  per-requester valid, bit i = requester i.
REQ-007 S_WREADY  output  NUM_REQ  per-requester ready; at most one bit high per cycle.
REQ-008 S_WDATA  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 M_WVALID  output  1  output valid.
REQ-010 M_WREADY  input  1  output ready from the downstream slice.
REQ-011 M_WDATA  output  DATA_W  output data.
REQ-012 M_WID  output  clog2(NUM_REQ)  source index of the current M_WDATA beat.

Function
REQ-013 A beat transfers on an input port when S_WVALID[i] and S_WREADY[i] are both high at a rising edge; a beat transfers on the output when M_WVALID and M_WREADY are both high.
REQ-014 The FSM has two states: IDLE and GRANT.
REQ-015 In IDLE, all S_WREADY are 0; if any S_WVALID bit is high, the next state is GRANT with grant index g = first requester with valid high, searching from ptr upward with wrap-around.
REQ-016 In GRANT, S_WREADY[g] = not full of the output buffer; all other S_WREADY bits are 0.
REQ-017 Each accepted beat increments beat_cnt; the FSM returns to IDLE in the cycle after the beat where beat_cnt reaches QUANTUM-1, or in the cycle after S_WVALID[g] is sampled low.
REQ-018 On leaving GRANT, ptr loads (g+1) mod NUM_REQ and beat_cnt clears.
REQ-019 The result is a one-cycle arbitration bubble between grants.
REQ-020 The output buffer holds 2 entries with ping-pong write and read pointers; each entry stores {id, data}.
REQ-021 Latency is one cycle: an accepted input beat appears on M_WVALID/M_WDATA at the next edge.
REQ-022 Full throughput of one beat per cycle within a grant while M_WREADY stays high.
REQ-023 Full buffer (2 entries): S_WREADY[g] = 0, and no beat is lost or duplicated.
REQ-024 Empty buffer: M_WVALID = 0.
REQ-025 Simultaneous push and pop with 1 entry held: occupancy stays 1.
REQ-026 M_WVALID never drops without a handshake, and M_WDATA/M_WID are stable while M_WVALID=1 and M_WREADY=0.
REQ-027 Output order equals input acceptance order.
REQ-028 A requester that drops valid while holding the grant loses it; the grant is not held.

Reset
REQ-029 While RST_I=1: state=IDLE, ptr=0, beat_cnt=0, buffer empty, S_WREADY=0, M_WVALID=0, M_WDATA=0, M_WID=0.
REQ-030 Reset asserted mid-grant discards buffered beats, and the first grant after reset starts the search at requester 0.
REQ-031 Outputs are valid from the first edge at which RST_I is sampled high.

Configuration
REQ-032 Macro REG_STREAM_ARB_FIXED_PRIO_EN, when defined: ptr is held at 0, so the lowest-index valid requester always wins; QUANTUM still limits grant length.
REQ-033 Macro undefined: round-robin arbitration as specified in REQ-015 and REQ-018.

Structure
REQ-034 Package reg_stream_pkg holds the FSM state encoding (IDLE, GRANT) and default constants for NUM_REQ, DATA_W and QUANTUM.
REQ-035 The 2-entry {id, data} buffer is a sub-module named arb_out_slice, with valid/ready ports on both sides.
REQ-036 The arbiter FSM and priority search stay in reg_stream_arb.

Verification
REQ-037 Reset release with S_WVALID=4'b0000 -> S_WREADY=0 and M_WVALID=0 for 10 cycles.
REQ-038 Requester 2 alone streams data 1..8 with M_WREADY=1, QUANTUM=4 -> output 1,2,3,4, one bubble cycle, then 5,6,7,8; M_WID=2 throughout.
REQ-039 All four requesters continuously valid, QUANTUM=4 -> grants run 0,1,2,3,0 in blocks of 4 beats; with REG_STREAM_ARB_FIXED_PRIO_EN defined -> only requester 0 is granted.
REQ-040 M_WREADY=0 for 5 cycles during a grant -> exactly 2 beats buffered, S_WREADY[g]=0, M_WDATA held; on release, beats drain in order with no loss.
REQ-041 Requester 1 drops valid after 2 beats while requester 3 is valid -> the grant passes to 3 after one IDLE cycle, and ptr becomes 2.
REQ-042 RST_I pulsed for 1 cycle with 2 beats buffered -> the next cycle shows M_WVALID=0 and state IDLE, and the next grant goes to the lowest valid requester.
